// File: rtl/fp_pkg.sv
// Shared binary32 helpers: field positions, canonical quiet NaN, NaN test and
// the reducer's state encoding.
package fp_pkg;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  localparam int SIGN   = 31;
  localparam int EXP_HI = 30;
  localparam int EXP_LO = 23;
  localparam int MAN_HI = 22;
  localparam int MAN_LO = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  function automatic logic is_nan(input logic [31:0] x);
    return (&x[EXP_HI:EXP_LO]) && (|x[MAN_HI:MAN_LO]);
  endfunction

endpackage

// File: rtl/compare.sv
// Binary32 A >= B over non-NaN operands; +0 orders above -0 because the
// comparison is done on a monotonic unsigned key of the bit pattern.
module compare
  import fp_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        ge
);

  // Negatives invert all bits so larger magnitude sorts lower; positives get
  // the sign bit forced high so they sort above every negative.
  function automatic logic [31:0] order_key(input logic [31:0] x);
    return x[SIGN] ? ~x : {1'b1, x[SIGN-1:0]};
  endfunction

  assign ge = (order_key(a) >= order_key(b));

endmodule

// File: rtl/fp_block_minmax.sv
// Streaming per-block min/max reducer for binary32 samples: tracks first-seen
// extreme values with indices, sample count, NaN and overflow status.
module fp_block_minmax
  import fp_pkg::*;
#(
  parameter  int MAX_LEN = 256,
  localparam int IW      = $clog2(MAX_LEN + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [31:0]   in_data,
  input  logic          in_valid,
  input  logic          in_last,
  output logic          in_ready,
  output logic [31:0]   out_max,
  output logic [31:0]   out_min,
  output logic [IW-1:0] out_max_idx,
  output logic [IW-1:0] out_min_idx,
  output logic [IW-1:0] out_count,
  output logic          out_nan,
  output logic          out_ovf,
  output logic          out_valid,
  input  logic          out_ready
);

  state_t        state_reg;
  logic [31:0]   max_reg, min_reg;
  logic [IW-1:0] max_idx_reg, min_idx_reg, count_reg;
  logic          have_val_reg, nan_reg, ovf_reg;
  logic          in_ready_reg, out_valid_reg;

  logic [31:0]   cmp_a [2];
  logic [31:0]   cmp_b [2];
  logic [1:0]    cmp_ge;

  // Path 0 asks "sample >= max", path 1 asks "min >= sample".
  assign cmp_a[0] = in_data;
  assign cmp_b[0] = max_reg;
  assign cmp_a[1] = min_reg;
  assign cmp_b[1] = in_data;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cmp
      compare u_cmp (
        .a  (cmp_a[gi]),
        .b  (cmp_b[gi]),
        .ge (cmp_ge[gi])
      );
    end
  endgenerate

  logic          xfer, sample_nan, load_first, upd_max, upd_min, blk_end;
  logic [IW-1:0] count_next;

  assign xfer       = in_valid && in_ready_reg;
  assign sample_nan = is_nan(in_data);
  assign count_next = count_reg + IW'(1);
  assign load_first = !sample_nan && !have_val_reg;
  assign upd_max    = !sample_nan && have_val_reg && cmp_ge[0] && (in_data != max_reg);
  assign upd_min    = !sample_nan && have_val_reg && cmp_ge[1] && (in_data != min_reg);
  assign blk_end    = in_last || (count_next == IW'(MAX_LEN));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      max_reg       <= '0;
      min_reg       <= '0;
      max_idx_reg   <= '0;
      min_idx_reg   <= '0;
      count_reg     <= '0;
      have_val_reg  <= 1'b0;
      nan_reg       <= 1'b0;
      ovf_reg       <= 1'b0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        HOLD: begin
          if (out_ready) begin
            state_reg     <= IDLE;
            max_reg       <= '0;
            min_reg       <= '0;
            max_idx_reg   <= '0;
            min_idx_reg   <= '0;
            count_reg     <= '0;
            have_val_reg  <= 1'b0;
            nan_reg       <= 1'b0;
            ovf_reg       <= 1'b0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
          end
        end
        default: begin
          if (xfer) begin
            count_reg <= count_next;
            if (sample_nan) nan_reg <= 1'b1;
            if (load_first) begin
              max_reg      <= in_data;
              min_reg      <= in_data;
              max_idx_reg  <= count_reg;
              min_idx_reg  <= count_reg;
              have_val_reg <= 1'b1;
            end
            if (upd_max) begin
              max_reg     <= in_data;
              max_idx_reg <= count_reg;
            end
            if (upd_min) begin
              min_reg     <= in_data;
              min_idx_reg <= count_reg;
            end
            if (blk_end) begin
              state_reg     <= HOLD;
              in_ready_reg  <= 1'b0;
              out_valid_reg <= 1'b1;
              ovf_reg       <= !in_last;
              // An all-NaN block reports the canonical quiet NaN at index 0.
              if (!have_val_reg && sample_nan) begin
                max_reg <= QNAN;
                min_reg <= QNAN;
              end
            end else begin
              state_reg <= ACCUM;
            end
          end
        end
      endcase
    end
  end

  assign in_ready    = in_ready_reg;
  assign out_max     = max_reg;
  assign out_min     = min_reg;
  assign out_max_idx = max_idx_reg;
  assign out_min_idx = min_idx_reg;
  assign out_count   = count_reg;
  assign out_nan     = nan_reg;
  assign out_ovf     = ovf_reg;
  assign out_valid   = out_valid_reg;

endmodule

// File: tb/tb_fp_block_minmax.sv
// Self-checking bench for fp_block_minmax: directed blocks from the test plan
// followed by random blocks scored against a sign/magnitude reference model.
module tb_fp_block_minmax;

  localparam int MAX_LEN = 4;
  localparam int IW      = 3;
  localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic          in_ready;
  logic [31:0]   out_max, out_min;
  logic [IW-1:0] out_max_idx, out_min_idx, out_count;
  logic          out_nan, out_ovf, out_valid;
  logic          out_ready = 1'b0;

  int errors = 0;
  int checks = 0;
  int blk_no = 0;

  typedef struct {
    logic [31:0] mx;
    logic [31:0] mn;
    int          mxi;
    int          mni;
    int          cnt;
    bit          nan;
    bit          ovf;
  } res_t;

  fp_block_minmax #(.MAX_LEN(MAX_LEN)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .out_max     (out_max),
    .out_min     (out_min),
    .out_max_idx (out_max_idx),
    .out_min_idx (out_min_idx),
    .out_count   (out_count),
    .out_nan     (out_nan),
    .out_ovf     (out_ovf),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit ref_is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  // Strict numeric order with -0 below +0.
  function automatic bit ref_gt(input logic [31:0] a, input logic [31:0] b);
    if (a[31] != b[31]) return b[31];
    if (!a[31]) return a[30:0] > b[30:0];
    return a[30:0] < b[30:0];
  endfunction

  function automatic res_t model(input logic [31:0] s[$], input bit last);
    res_t r;
    bit   have;
    have  = 0;
    r.mx  = CANON_NAN;
    r.mn  = CANON_NAN;
    r.mxi = 0;
    r.mni = 0;
    r.nan = 0;
    r.cnt = s.size();
    r.ovf = !last;
    for (int i = 0; i < s.size(); i++) begin
      if (ref_is_nan(s[i])) r.nan = 1;
      else if (!have) begin
        have = 1; r.mx = s[i]; r.mn = s[i]; r.mxi = i; r.mni = i;
      end else begin
        if (ref_gt(s[i], r.mx)) begin r.mx = s[i]; r.mxi = i; end
        if (ref_gt(r.mn, s[i])) begin r.mn = s[i]; r.mni = i; end
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] gen_sample(input logic [31:0] prev);
    logic [31:0] x;
    x = $urandom;
    case ($urandom_range(0, 7))
      0: x = $urandom;
      1: x = {x[31], 31'd0};
      2: x = {x[31], 8'hFF, 23'd0};
      3: x = {x[31], 8'hFF, 22'd0, 1'b1} | {9'd0, x[22:0]};
      4: x = prev;
      default: x = {x[31], 8'(8'd124 + 8'($urandom_range(0, 6))), x[22:0]};
    endcase
    return x;
  endfunction

  task automatic drive_samples(input logic [31:0] s[$], input bit last);
    int n;
    for (int i = 0; i < s.size(); i++) begin
      in_data  = s[i];
      in_valid = 1'b1;
      in_last  = last && (i == s.size() - 1);
      if (i > 0) chk("in_ready_stream", 32'(in_ready), 32'd1);
      n = 0;
      while (in_ready !== 1'b1 && n < 20) begin
        tick();
        n++;
      end
      chk("in_ready_wait", 32'(in_ready), 32'd1);
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_out(input res_t m);
    chk("out_valid", 32'(out_valid), 32'd1);
    chk("out_max", out_max, m.mx);
    chk("out_min", out_min, m.mn);
    chk("out_max_idx", 32'(out_max_idx), 32'(m.mxi));
    chk("out_min_idx", 32'(out_min_idx), 32'(m.mni));
    chk("out_count", 32'(out_count), 32'(m.cnt));
    chk("out_nan", 32'(out_nan), 32'(m.nan));
    chk("out_ovf", 32'(out_ovf), 32'(m.ovf));
    chk("in_ready_hold", 32'(in_ready), 32'd0);
  endtask

  // Optionally keeps a pending sample on the bus while the result is held.
  task automatic expect_and_release(input res_t m, input int hold, input bit stall,
                                    input logic [31:0] nxt);
    check_out(m);
    $display("block %0d: count=%0d max=%h@%0d min=%h@%0d nan=%0d ovf=%0d",
             blk_no, out_count, out_max, out_max_idx, out_min, out_min_idx, out_nan, out_ovf);
    blk_no++;
    if (stall) begin
      in_data  = nxt;
      in_valid = 1'b1;
      in_last  = 1'b1;
    end
    for (int h = 0; h < hold; h++) begin
      tick();
      check_out(m);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("out_valid_drop", 32'(out_valid), 32'd0);
    chk("in_ready_reopen", 32'(in_ready), 32'd1);
  endtask

  task automatic run_block(input logic [31:0] s[$], input bit last, input int hold);
    res_t m;
    m = model(s, last);
    drive_samples(s, last);
    expect_and_release(m, hold, 1'b0, 32'd0);
  endtask

  task automatic check_reset_state();
    chk("rst_out_max", out_max, 32'd0);
    chk("rst_out_min", out_min, 32'd0);
    chk("rst_max_idx", 32'(out_max_idx), 32'd0);
    chk("rst_min_idx", 32'(out_min_idx), 32'd0);
    chk("rst_count", 32'(out_count), 32'd0);
    chk("rst_nan", 32'(out_nan), 32'd0);
    chk("rst_ovf", 32'(out_ovf), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] q[$];
    logic [31:0] prev;
    res_t        m;
    int          len;
    bit          last;

    repeat (3) tick();
    check_reset_state();
    rst_n = 1'b1;
    tick();

    // Mixed signs, max and min at different indices.
    q = {};
    q.push_back(32'h3F80_0000); q.push_back(32'hC040_0000);
    q.push_back(32'h4000_0000); q.push_back(32'h3F00_0000);
    run_block(q, 1'b1, 0);

    // Bit-identical tie keeps index 0; +0 beats -0.
    q = {};
    q.push_back(32'h3F80_0000); q.push_back(32'h3F80_0000);
    run_block(q, 1'b1, 1);
    q = {};
    q.push_back(32'h8000_0000); q.push_back(32'h0000_0000);
    run_block(q, 1'b1, 0);

    // Leading NaN, then an all-NaN single-sample block.
    q = {};
    q.push_back(32'h7FC0_0001); q.push_back(32'h3F80_0000);
    run_block(q, 1'b1, 0);
    q = {};
    q.push_back(32'h7F80_0001);
    run_block(q, 1'b1, 0);

    // Overflow at MAX_LEN with a fifth sample stalled through a 5-cycle hold.
    q = {};
    q.push_back(32'h4080_0000); q.push_back(32'hBF80_0000);
    q.push_back(32'h4100_0000); q.push_back(32'hC100_0000);
    m = model(q, 1'b0);
    drive_samples(q, 1'b0);
    expect_and_release(m, 5, 1'b1, 32'h4140_0000);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    q = {};
    q.push_back(32'h4140_0000);
    expect_and_release(model(q, 1'b1), 0, 1'b0, 32'd0);

    // Reset after two samples of an unfinished block.
    in_data  = 32'h3F80_0000;
    in_valid = 1'b1;
    tick();
    in_data = 32'h4000_0000;
    tick();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state();
    tick();
    #3;
    rst_n = 1'b1;
    tick();
    q = {};
    q.push_back(32'hC2C8_0000);
    run_block(q, 1'b1, 0);

    // Random blocks.
    prev = 32'h3F80_0000;
    for (int b = 0; b < 40; b++) begin
      len  = $urandom_range(1, MAX_LEN);
      last = 1'b1;
      if (len == MAX_LEN && $urandom_range(0, 3) == 0) last = 1'b0;
      q = {};
      for (int i = 0; i < len; i++) begin
        prev = gen_sample(prev);
        q.push_back(prev);
      end
      run_block(q, last, $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fp_block_minmax.md
# fp_block_minmax

Streaming single-precision min/max reducer that sits directly downstream of the `compare` (A >= B) stage. It accepts a block of IEEE-754 binary32 samples over a valid/ready handshake and drives two `compare` instances to track the running maximum and minimum. At the end of the block it presents both values, their sample indices, the sample count and status flags on a registered valid/ready output.

## Interface
Parameters:
- `MAX_LEN`, default 256: maximum samples per block; index/count width `IW = $clog2(MAX_LEN+1)`.

Ports:
- `clk` in 1: the design's single clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_data` in 32: binary32 sample.
- `in_valid` in 1: sample present.
- `in_last` in 1: final sample of the block; qualified by `in_valid`.
- `in_ready` out 1: block can accept a sample.
- `out_max` out 32: largest non-NaN sample.
- `out_min` out 32: smallest non-NaN sample.
- `out_max_idx` out IW: index of first occurrence of `out_max`.
- `out_min_idx` out IW: index of first occurrence of `out_min`.
- `out_count` out IW: samples accepted in the block.
- `out_nan` out 1: at least one NaN sample seen (exponent FF, mantissa ≠ 0).
- `out_ovf` out 1: block was terminated at `MAX_LEN` without `in_last`.
- `out_valid` out 1: result present.
- `out_ready` in 1: consumer accepts result.

## Operation
- States: IDLE (no sample yet in block), ACCUM (≥1 sample held), HOLD (result presented).
- A transfer occurs when `in_valid && in_ready`. `in_ready` = 1 in IDLE/ACCUM and 0 in HOLD.
- Index of a sample = count of prior accepted samples in the block (first sample = 0).
- A non-NaN sample arriving while no non-NaN value is held loads both max and min and sets both indices to its index.
- For a subsequent non-NaN sample `c`:
  - Max updates iff `c` is strictly greater than the held max: `compare(c, max) == 1` and the bit patterns differ.
  - Min updates iff `c` is strictly less than the held min: `compare(min, c) == 1` and the bit patterns differ.
  - Bit-identical values never update, so ties keep the earliest index.
  - +0 (00000000) orders above −0 (80000000), as `compare` orders them.
- A NaN sample sets the sticky `nan` flag, counts toward `out_count`, and never updates max/min.
- A block with no non-NaN samples reports max = min = 7FC00000, both indices 0, `out_nan` = 1.
- End of block:
  - `in_last` on a transfer causes the state to go to HOLD.
  - Otherwise, the transfer that brings the count to `MAX_LEN` ends the block with `out_ovf` = 1.
- HOLD → IDLE on `out_valid && out_ready`. All accumulators clear on that edge. Status flags are per-block.
- Transitions: IDLE --xfer & !end--> ACCUM; IDLE/ACCUM --xfer & end--> HOLD; ACCUM --no xfer--> ACCUM; HOLD --out_ready--> IDLE.

## Timing
- All outputs registered. Reset values: `out_*` data 0, `out_nan` 0, `out_ovf` 0, `out_valid` 0, `in_ready` 1. State resets to IDLE.
- Throughput: one sample per cycle, no bubbles inside a block.
- Latency: `out_valid` rises the cycle after the final accepted sample.
- Bubble between blocks: the result occupies at least one HOLD cycle. The next block's first sample is accepted in the cycle after the output handshake, so the minimum gap is 1 cycle.
- Output data is stable while `out_valid && !out_ready`.
- `rst_n` assertion mid-block or in HOLD clears everything immediately. The partial block is discarded and no output is produced.
- A single-sample block (`in_last` on the first sample) is legal: count 1, max = min = that sample, indices 0.

## Structure
- Shared package `fp_pkg`:
  - `QNAN` = 32'h7FC00000.
  - Field ranges SIGN = 31, EXP = 30:23, MAN = 22:0.
  - Function `is_nan(x)`.
- Sub-module: the existing `compare`, instantiated twice (max path, min path). No new sub-module.
- Registers: state (2 bits), max, min, two indices, count, `have_val`, `nan`, `ovf`.

## Test plan
- Samples 3F800000, C0400000, 40000000, 3F000000 (last) → max 40000000 idx 2, min C0400000 idx 1, count 4, `out_valid` the cycle after last.
- Samples 3F800000, 3F800000 (last), then 80000000, 00000000 (last) → block 1: max = min idx 0. Block 2: max 00000000 idx 1, min 80000000 idx 0.
- Samples 7FC00001, 3F800000 (last) → max = min 3F800000 idx 1, `out_nan` 1. Single-sample block 7F800001 → max = min 7FC00000, nan 1, count 1.
- `MAX_LEN` = 4, five samples with no `in_last` → HOLD after the 4th with `out_ovf` 1 and count 4. The 5th is stalled (`in_ready` 0) until `out_ready`, then becomes index 0 of the next block.
- `out_ready` held low 5 cycles in HOLD → outputs stable and `in_ready` 0. On release, IDLE next cycle and a new sample is accepted.
- `rst_n` pulsed low after 2 samples → all outputs 0 and `in_ready` 1 asynchronously. A subsequent 1-sample block reports count 1.
